// File: rtl/systolic_seq_pkg.sv
// State encoding and default array latency shared by the tile sequencer files.
package systolic_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BIAS    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_FINISH  = 3'd4
  } seq_state_t;

  function automatic int default_sa_latency(input int array_n, input int array_m);
    return array_n + array_m;
  endfunction

endpackage

// File: rtl/seq_delay_line.sv
// Hold-able 1-bit shift register: out_bit follows in_bit after DEPTH unheld cycles.
// hold freezes every tap; any_valid reports whether any marker is still in flight.
module seq_delay_line #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic in_bit,
  output logic out_bit,
  output logic any_valid
);

  logic [DEPTH-1:0] taps;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taps <= '0;
    end else if (!hold) begin
      taps[0] <= in_bit;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign out_bit   = taps[DEPTH-1];
  assign any_valid = |taps;

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Tile-loop sequencer for a systolic array; defining SEQ_PERF_CNT_EN adds a busy-cycle counter.
// Reads start the cycle after launch, writes trail each tile's last read by SA_LATENCY; stall freezes all state.
module systolic_tile_sequencer
  import systolic_seq_pkg::*;
#(
  parameter int ARRAY_N         = 4,
  parameter int ARRAY_M         = 4,
  parameter int LOOP_WIDTH      = 16,
  parameter int OBUF_ADDR_WIDTH = 16,
  parameter int BBUF_ADDR_WIDTH = 16,
  parameter int SA_LATENCY      = default_sa_latency(ARRAY_N, ARRAY_M)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stall,
  input  logic [LOOP_WIDTH-1:0]      cfg_k,
  input  logic [LOOP_WIDTH-1:0]      cfg_tiles,
  input  logic [OBUF_ADDR_WIDTH-1:0] cfg_obuf_base,
  input  logic [BBUF_ADDR_WIDTH-1:0] cfg_bias_base,
  input  logic                       cfg_bias_en,
  output logic                       ibuf_read_req,
  output logic                       wbuf_read_req,
  output logic                       acc_clear,
  output logic                       bias_read_req,
  output logic [BBUF_ADDR_WIDTH-1:0] bias_read_addr,
  output logic                       bias_prev_sw,
  output logic                       obuf_write_req,
  output logic [OBUF_ADDR_WIDTH-1:0] obuf_write_addr,
  output logic                       busy,
  output logic                       done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                perf_cycles
`endif
);

  localparam logic [LOOP_WIDTH-1:0]      LOOP_ONE = 1;
  localparam logic [OBUF_ADDR_WIDTH-1:0] OBUF_ONE = 1;

  seq_state_t state, state_next;

  logic [LOOP_WIDTH-1:0]      k_q, tiles_q, k_cnt, tile_idx, k_last, job_tiles;
  logic [OBUF_ADDR_WIDTH-1:0] obuf_base_q, wr_idx;
  logic [BBUF_ADDR_WIDTH-1:0] bias_base_q;
  logic bias_en_q, pending, accept, go, job_bias;
  logic read_fire, last_read, last_tile, dl_out, dl_any;

  // A start seen under stall is parked in pending until the stall clears.
  assign accept    = start && (state == ST_IDLE) && !pending;
  assign go        = (accept || pending) && !stall;
  assign job_tiles = accept ? cfg_tiles : tiles_q;
  assign job_bias  = accept ? cfg_bias_en : bias_en_q;
  assign k_last    = (k_q == '0) ? '0 : k_q - LOOP_ONE;
  assign read_fire = (state == ST_COMPUTE) && !stall;
  assign last_read = read_fire && (k_cnt == k_last);
  assign last_tile = (tile_idx == tiles_q - LOOP_ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (go) begin
          if (job_tiles == '0) state_next = ST_FINISH;
          else if (job_bias)   state_next = ST_BIAS;
          else                 state_next = ST_COMPUTE;
        end
      end
      ST_BIAS:    if (!stall) state_next = ST_COMPUTE;
      ST_COMPUTE: begin
        if (last_read) begin
          if (last_tile)      state_next = ST_DRAIN;
          else if (bias_en_q) state_next = ST_BIAS;
          else                state_next = ST_COMPUTE;
        end
      end
      ST_DRAIN:   if (!stall && !dl_any) state_next = ST_FINISH;
      ST_FINISH:  if (!stall) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ibuf_read_req   = 1'b0;
    wbuf_read_req   = 1'b0;
    acc_clear       = 1'b0;
    bias_read_req   = 1'b0;
    busy            = (state != ST_IDLE);
    bias_prev_sw    = (state != ST_IDLE) && !bias_en_q;
    bias_read_addr  = bias_base_q + BBUF_ADDR_WIDTH'(tile_idx);
    obuf_write_req  = dl_out && !stall;
    obuf_write_addr = obuf_base_q + wr_idx;
    case (state)
      ST_BIAS: bias_read_req = !stall;
      ST_COMPUTE: begin
        ibuf_read_req = !stall;
        wbuf_read_req = !stall;
        acc_clear     = !stall && (k_cnt == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q         <= '0;
      tiles_q     <= '0;
      obuf_base_q <= '0;
      bias_base_q <= '0;
      bias_en_q   <= 1'b0;
      pending     <= 1'b0;
      k_cnt       <= '0;
      tile_idx    <= '0;
      wr_idx      <= '0;
      done        <= 1'b0;
    end else begin
      pending <= (state == ST_IDLE) && (accept || pending) && stall;
      done    <= (state == ST_FINISH) && !stall;
      if (obuf_write_req) wr_idx <= wr_idx + OBUF_ONE;
      if (accept) begin
        k_q         <= cfg_k;
        tiles_q     <= cfg_tiles;
        obuf_base_q <= cfg_obuf_base;
        bias_base_q <= cfg_bias_base;
        bias_en_q   <= cfg_bias_en;
        k_cnt       <= '0;
        tile_idx    <= '0;
        wr_idx      <= '0;
      end else if (read_fire) begin
        if (last_read) begin
          k_cnt    <= '0;
          tile_idx <= tile_idx + LOOP_ONE;
        end else begin
          k_cnt <= k_cnt + LOOP_ONE;
        end
      end
    end
  end

  seq_delay_line #(.DEPTH(SA_LATENCY)) u_delay (
    .clk       (clk),
    .reset     (reset),
    .hold      (stall),
    .in_bit    (last_read),
    .out_bit   (dl_out),
    .any_valid (dl_any)
  );

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 perf_cycles <= '0;
    else if (accept)            perf_cycles <= '0;
    else if (state != ST_IDLE)  perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Scoreboard bench: a job-level timeline model (in unstalled cycles since start) feeds event queues a monitor drains.
`timescale 1ns/1ps
module tb_systolic_tile_sequencer;

  localparam int SA = 4 + 4;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, stall = 1'b0;
  logic [15:0] cfg_k = '0, cfg_tiles = '0, cfg_obuf_base = '0, cfg_bias_base = '0;
  logic cfg_bias_en = 1'b0;
  logic ibuf_read_req, wbuf_read_req, acc_clear, bias_read_req, bias_prev_sw;
  logic obuf_write_req, busy, done;
  logic [15:0] bias_read_addr, obuf_write_addr;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  typedef struct { int u; int val; } ev_t;
  ev_t bias_q[$], rd_q[$], wr_q[$], done_q[$];

  int  checks = 0, errors = 0;
  int  u_cnt = 0, cyc = 0, wr_seen = 0, rd_seen = 0, first_act = 0;
  bit  exp_prev_sw = 1'b0;

  systolic_tile_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .cfg_k(cfg_k), .cfg_tiles(cfg_tiles), .cfg_obuf_base(cfg_obuf_base),
    .cfg_bias_base(cfg_bias_base), .cfg_bias_en(cfg_bias_en),
    .ibuf_read_req(ibuf_read_req), .wbuf_read_req(wbuf_read_req), .acc_clear(acc_clear),
    .bias_read_req(bias_read_req), .bias_read_addr(bias_read_addr), .bias_prev_sw(bias_prev_sw),
    .obuf_write_req(obuf_write_req), .obuf_write_addr(obuf_write_addr),
    .busy(busy), .done(done)
`ifdef SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint all_outputs();
    return {ibuf_read_req, wbuf_read_req, acc_clear, bias_read_req, bias_read_addr,
            bias_prev_sw, obuf_write_req, obuf_write_addr, busy, done};
  endfunction

  // Monitor: u_cnt is the number of unstalled cycles since the start cycle.
  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (reset) begin
      if (stall)
        check("strobes_during_stall",
              {ibuf_read_req, wbuf_read_req, acc_clear, bias_read_req, obuf_write_req}, 0);
      if (ibuf_read_req != wbuf_read_req) check("ibuf_wbuf_pair", ibuf_read_req, wbuf_read_req);
      if (acc_clear && !ibuf_read_req) check("acc_clear_without_read", 1, 0);
      if (bias_read_req) begin
        if (bias_q.size() == 0) check("unexpected_bias_read", 1, 0);
        else begin
          e = bias_q.pop_front();
          check("bias_read_time", u_cnt, e.u);
          check("bias_read_addr", bias_read_addr, e.val);
        end
      end
      if (ibuf_read_req) begin
        rd_seen++;
        if (rd_q.size() == 0) check("unexpected_read", 1, 0);
        else begin
          e = rd_q.pop_front();
          check("read_time", u_cnt, e.u);
          check("acc_clear", acc_clear, e.val);
        end
      end
      if (obuf_write_req) begin
        wr_seen++;
        if (wr_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = wr_q.pop_front();
          check("write_time", u_cnt, e.u);
          check("write_addr", obuf_write_addr, e.val);
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = done_q.pop_front();
          check("done_time", u_cnt, e.u);
          check("busy_low_at_done", busy, 0);
`ifdef SEQ_PERF_CNT_EN
          check("perf_cycles", perf_cycles, cyc - first_act - 1);
`endif
        end
      end
      if (busy) check("bias_prev_sw", bias_prev_sw, exp_prev_sw);
      if (u_cnt == 0 && !stall) first_act = cyc;
      if (!stall) u_cnt++;
    end
  end

  // Job timeline from the sequencing rules, in unstalled cycles after start.
  task automatic model_job(input int k, input int tiles, input int ben, input int ob, input int bb);
    int ke, base, last;
    ke = (k == 0) ? 1 : k;
    last = 0;
    for (int t = 0; t < tiles; t++) begin
      base = 1 + t * (ke + ben);
      if (ben != 0) bias_q.push_back(ev_t'{base, (bb + t) % 65536});
      for (int j = 0; j < ke; j++) rd_q.push_back(ev_t'{base + ben + j, (j == 0) ? 1 : 0});
      last = base + ben + ke - 1;
      wr_q.push_back(ev_t'{last + SA, (ob + t) % 65536});
    end
    done_q.push_back(ev_t'{(tiles == 0) ? 2 : last + SA + 3, 1});
    exp_prev_sw = (ben == 0);
  endtask

  task automatic launch(input int k, input int tiles, input int ben, input int ob, input int bb,
                        input bit stalled);
    @(posedge clk); #1;
    cfg_k = 16'(k); cfg_tiles = 16'(tiles); cfg_bias_en = (ben != 0);
    cfg_obuf_base = 16'(ob); cfg_bias_base = 16'(bb);
    start = 1'b1; stall = stalled; u_cnt = 0;
  endtask

  task automatic flush();
    bias_q.delete(); rd_q.delete(); wr_q.delete(); done_q.delete();
  endtask

  task automatic run_job(input int k, input int tiles, input int ben, input int ob, input int bb,
                         input int stall_pct, input int stall_at, input int stall_len,
                         input bit start_stalled, input bit poke);
    int n, rd0;
    rd0 = rd_seen;
    model_job(k, tiles, ben, ob, bb);
    launch(k, tiles, ben, ob, bb, start_stalled);
    n = 0;
    while (done_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      start = poke && (n == 2);
      cfg_k = 16'($urandom); cfg_tiles = 16'($urandom); cfg_bias_en = $urandom_range(1);
      cfg_obuf_base = 16'($urandom); cfg_bias_base = 16'($urandom);
      if (start_stalled && n < 3)                      stall = 1'b1;
      else if (n >= stall_at && n < stall_at + stall_len) stall = 1'b1;
      else                                             stall = ($urandom_range(99) < stall_pct);
    end
    start = 1'b0; stall = 1'b0;
    check("job_completes", done_q.size(), 0);
    check("events_outstanding", bias_q.size() + rd_q.size() + wr_q.size(), 0);
    check("read_cycles", rd_seen - rd0, tiles * ((k == 0) ? 1 : k));
    flush();
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_mid_drain();
    int w0;
    model_job(2, 1, 1, 'h40, 5);
    launch(2, 1, 1, 'h40, 5, 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("reads_done_before_reset", rd_q.size(), 0);
    check("write_pending_in_drain", wr_q.size(), 1);
    reset = 1'b0;
    flush();
    @(negedge clk);
    check("outputs_zero_in_reset", all_outputs(), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    w0 = wr_seen;
    repeat (SA + 6) @(posedge clk);
    check("no_late_write", wr_seen - w0, 0);
    check("idle_after_reset", busy, 0);
    check("no_done_after_reset", done_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, tiles, ben, pct;
    bit sst;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("idle_after_release", busy, 0);

    run_job(3, 2, 1, 'h10, 'h10, 0, 0, 0, 1'b0, 1'b0);     // basic 4x4 job with bias
    run_job(3, 2, 0, 'h20, 'h00, 0, 0, 0, 1'b0, 1'b0);     // bias disabled
    run_job(4, 2, 1, 'h30, 'h08, 0, 3, 5, 1'b0, 1'b0);     // 5-cycle stall mid-compute
    run_job(2, 2, 1, 'hFFFF, 'h100, 0, 0, 0, 1'b0, 1'b0);  // output address wrap
    run_job(5, 0, 1, 'h70, 'h07, 0, 0, 0, 1'b0, 1'b0);     // zero tiles
    run_job(2, 1, 1, 'h50, 'h03, 0, 0, 0, 1'b1, 1'b0);     // start under stall
    run_job(2, 3, 0, 'h60, 'h00, 0, 0, 0, 1'b0, 1'b1);     // start while busy ignored
    run_job(0, 2, 1, 'h80, 'hFFFF, 0, 0, 0, 1'b0, 1'b0);   // k=0 behaves as k=1
    reset_mid_drain();

    for (int i = 0; i < 25; i++) begin
      k     = $urandom_range(5);
      tiles = $urandom_range(4);
      ben   = $urandom_range(1);
      pct   = $urandom_range(30);
      sst   = ($urandom_range(3) == 0);
      run_job(k, tiles, ben, $urandom_range(65535), $urandom_range(65535), pct, 0, 0,
              sst, !sst && (tiles > 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_tile_sequencer.md
SYSTOLIC_TILE_SEQUENCER -- requirements
Module: systolic_tile_sequencer

Interface
REQ-001 SHALL have parameter ARRAY_N, default 4: PE rows (reduction lanes).
REQ-002 SHALL have parameter ARRAY_M, default 4: PE columns (output lanes).
REQ-003 SHALL have parameter LOOP_WIDTH, default 16: width of the cfg_k and cfg_tiles counters.
REQ-004 SHALL have parameter OBUF_ADDR_WIDTH, default 16: output-buffer address width.
REQ-005 SHALL have parameter BBUF_ADDR_WIDTH, default 16: bias-buffer address width.
REQ-006 SHALL have parameter SA_LATENCY, default ARRAY_N+ARRAY_M: cycles from the last operand read to the valid array result.
REQ-007 Port: clk, input, 1, the only clock.
REQ-008 Port: reset, input, 1, asynchronous, active-low.
REQ-009 Port: start, input, 1, single-cycle job launch.
REQ-010 Port: stall, input, 1, freezes the sequencer while high.
REQ-011 Port: cfg_k, input, LOOP_WIDTH, reduction steps per tile.
REQ-012 Port: cfg_tiles, input, LOOP_WIDTH, tiles per job.
REQ-013 Port: cfg_obuf_base, input, OBUF_ADDR_WIDTH, first output address.
REQ-014 Port: cfg_bias_base, input, BBUF_ADDR_WIDTH, first bias address.
REQ-015 Port: cfg_bias_en, input, 1, enables bias loading.
REQ-016 Port: ibuf_read_req, output, 1, activation-buffer read strobe.
REQ-017 Port: wbuf_read_req, output, 1, weight-buffer read strobe.
REQ-018 Port: acc_clear, output, 1, array accumulator clear.
REQ-019 Port: bias_read_req, output, 1, bias-buffer read strobe.
REQ-020 Port: bias_read_addr, output, BBUF_ADDR_WIDTH, bias-buffer read address.
REQ-021 Port: bias_prev_sw, output, 1, selects bias (0) or previous partial sum (1).
REQ-022 Port: obuf_write_req, output, 1, output-buffer write strobe.
REQ-023 Port: obuf_write_addr, output, OBUF_ADDR_WIDTH, output-buffer write address.
REQ-024 Port: busy, output, 1, high while a job is in progress.
REQ-025 Port: done, output, 1, one-cycle pulse when a job completes.

Function
REQ-026 SHALL implement the FSM states IDLE, BIAS, COMPUTE, DRAIN, FINISH.
REQ-027 IDLE->BIAS SHALL occur on start; cfg_* SHALL be latched on that cycle.
REQ-028 If cfg_bias_en=0, IDLE->COMPUTE SHALL occur instead, with bias_prev_sw=1.
REQ-029 BIAS SHALL last one cycle and assert bias_read_req with bias_read_addr = base + tile index.
REQ-030 COMPUTE SHALL assert ibuf_read_req and wbuf_read_req for exactly max(cfg_k,1) unstalled cycles.
REQ-031 acc_clear SHALL be high only on the first COMPUTE cycle of each tile.
REQ-032 obuf_write_req SHALL pulse exactly SA_LATENCY unstalled cycles after a tile's last read, via a delay line.
REQ-033 obuf_write_addr SHALL be base + tile index, modulo 2^OBUF_ADDR_WIDTH (wraps).
REQ-034 After a tile's last read, the next tile SHALL begin immediately (BIAS or COMPUTE), overlapping the drain.
REQ-035 After the last tile, the FSM SHALL enter DRAIN until the delay line is empty, then FINISH.
REQ-036 FINISH SHALL pulse done for 1 cycle, then return to IDLE; busy SHALL be high in all states except IDLE.
REQ-037 stall=1 SHALL hold the state, counters and delay line, and deassert all read/write strobes.
REQ-038 start SHALL be ignored while busy.
REQ-039 cfg_tiles=0 SHALL go IDLE->FINISH with no strobes.
REQ-040 Simultaneous stall and start in IDLE SHALL latch the job, with the first transition deferred until stall=0.

Reset
REQ-041 Asserting reset (low), including mid-job, SHALL force IDLE and clear counters and the delay line.
REQ-042 During reset, all outputs SHALL be 0.

Configuration
REQ-043 With SEQ_PERF_CNT_EN defined, the block SHALL add output perf_cycles (32 bits), counting busy cycles of the last job, including stalls.
REQ-044 perf_cycles SHALL hold its value until the next start; without the macro, the port and logic SHALL be absent.

Structure
REQ-045 Package systolic_seq_pkg SHALL hold the state encoding and the default SA_LATENCY expression.
REQ-046 Sub-module seq_delay_line SHALL be a parametrised-depth shift register with a hold enable and an any-valid flag.

Verification
REQ-047 ARRAY 4x4, cfg_k=3, cfg_tiles=2, bias_en=1, base 0x10 -> bias reads at 0x10/0x11; 6 read cycles; writes at 0x10/0x11, each 8 cycles after its last read; done once.
REQ-048 cfg_bias_en=0 -> no bias_read_req; bias_prev_sw=1 throughout.
REQ-049 stall high for 5 cycles mid-COMPUTE -> total read cycles unchanged; write delay extended by 5.
REQ-050 cfg_obuf_base=0xFFFF, cfg_tiles=2 -> writes at 0xFFFF, then 0x0000.
REQ-051 reset low during DRAIN -> next cycle all outputs 0; no late obuf_write_req.
REQ-052 cfg_tiles=0 -> done 2 cycles after start; no strobes.
